// File: rtl/program_loader.sv
// Receives a byte stream (16-bit word count header followed by little-endian words)
// and writes it into instruction memory, holding the core in reset until the image is complete.
module program_loader #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int IDXW = $clog2(DEPTH_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        DONE,
        ERR
    } LoaderState;

    LoaderState state, stateNext;

    logic [7:0]      countLow;
    logic [15:0]     wordCount;
    logic [IDXW-1:0] wordIndex;
    logic [1:0]      lane;
    logic [23:0]     assembly;
    logic [15:0]     headerCount;
    logic            headerBad;
    logic            lastWord;
    logic            acceptState;
    logic            transfer;

    assign acceptState = (state == HDR0) || (state == HDR1) || (state == DATA);
    assign byte_ready  = acceptState;
    assign busy        = acceptState;
    assign done        = (state == DONE);
    assign error       = (state == ERR);
    assign transfer    = byte_valid && acceptState;

    assign headerCount = {byte_data, countLow};
    assign headerBad   = (headerCount == 16'd0) || (32'(headerCount) > DEPTH_WORDS);
    assign lastWord    = (32'(wordIndex) + 32'd1) == 32'(wordCount);

    always_ff @(posedge clk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) stateNext = HDR0;
            end
            HDR0: begin
                if (transfer) stateNext = HDR1;
            end
            HDR1: begin
                if (transfer) stateNext = headerBad ? ERR : DATA;
            end
            DATA: begin
                // The final write is issued on the same edge that enters DONE
                if (transfer && (lane == 2'd3) && lastWord) stateNext = DONE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            countLow  <= '0;
            wordCount <= '0;
            wordIndex <= '0;
            lane      <= '0;
            assembly  <= '0;
            imem_we   <= 1'b0;
            imem_addr <= BASE_ADDR;
            imem_wd   <= '0;
            core_hold <= 1'b1;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    // Hold stays asserted through the final write cycle, then drops
                    if (start) begin
                        core_hold <= 1'b1;
                        wordIndex <= '0;
                        lane      <= '0;
                    end else if (state == DONE) begin
                        core_hold <= 1'b0;
                    end
                end
                HDR0: begin
                    if (transfer) countLow <= byte_data;
                end
                HDR1: begin
                    if (transfer) begin
                        wordCount <= headerCount;
                        wordIndex <= '0;
                        lane      <= '0;
                    end
                end
                DATA: begin
                    if (transfer) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: assembly[7:0]   <= byte_data;
                            2'd1: assembly[15:8]  <= byte_data;
                            2'd2: assembly[23:16] <= byte_data;
                            default: begin
                                imem_we   <= 1'b1;
                                imem_wd   <= {byte_data, assembly};
                                imem_addr <= BASE_ADDR + (32'(wordIndex) << 2);
                                wordIndex <= wordIndex + 1'b1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares whenever imem_we is seen.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;

    int checkCount = 0;
    int passCount  = 0;
    logic [63:0] expQ[$];

    program_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk),
        .areset(areset),
        .start(start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wd(imem_wd),
        .core_hold(core_hold),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    // Presents one byte starting at a negedge and returns at the negedge after it was accepted
    task automatic applyStimulus(input logic [7:0] b, input bit gap);
        int waitCycles = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (waitCycles >= 20) begin
            checkCount++;
            $display("[TB] FAIL byteTimeout: byte_ready got 0 expected 1");
        end
        @(negedge clk);
        byte_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".core_hold"}, 32'(core_hold), 32'd1);
        checkOutput({tag, ".byte_ready"}, 32'(byte_ready), 32'd0);
        checkOutput({tag, ".imem_we"}, 32'(imem_we), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".error"}, 32'(error), 32'd0);
        checkOutput({tag, ".imem_addr"}, imem_addr, 32'h0);
        checkOutput({tag, ".imem_wd"}, imem_wd, 32'h0);
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpectedWrite: got addr %h data %h expected no write", imem_addr, imem_wd);
            end else begin
                logic [63:0] exp;
                exp = expQ.pop_front();
                checkOutput("writeAddr", imem_addr, exp[63:32]);
                checkOutput("writeData", imem_wd, exp[31:0]);
                checkOutput("holdDuringWrite", 32'(core_hold), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] img1 [10];
        img1 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

        repeat (3) @(negedge clk);
        areset = 1'b0;
        checkReset("reset");

        // Basic two-word image, continuous stream
        expQ.push_back({32'h0, 32'h00100513});
        expQ.push_back({32'h4, 32'h00200593});
        pulseStart();
        for (int i = 0; i < 10; i++) applyStimulus(img1[i], 1'b0);
        checkOutput("lastWriteCycle.we", 32'(imem_we), 32'd1);
        checkOutput("lastWriteCycle.done", 32'(done), 32'd1);
        checkOutput("lastWriteCycle.hold", 32'(core_hold), 32'd1);
        @(negedge clk);
        checkOutput("holdReleased", 32'(core_hold), 32'd0);
        checkOutput("doneStays", 32'(done), 32'd1);

        // Start from DONE re-asserts hold; then same image with gaps
        pulseStart();
        checkOutput("restart.hold", 32'(core_hold), 32'd1);
        checkOutput("restart.done", 32'(done), 32'd0);
        expQ.push_back({32'h0, 32'h00100513});
        expQ.push_back({32'h4, 32'h00200593});
        for (int i = 0; i < 10; i++) begin
            checkOutput("gapBusy", 32'(busy), 32'd1);
            applyStimulus(img1[i], 1'b1);
        end
        checkOutput("gapDone", 32'(done), 32'd1);
        checkOutput("gapHold", 32'(core_hold), 32'd0);

        // Extra bytes in DONE are refused
        byte_data  = 8'hAA;
        byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("doneRefuse", 32'(byte_ready), 32'd0);
            @(negedge clk);
        end
        byte_valid = 1'b0;

        // Zero-length header
        pulseStart();
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("zeroHdr.error", 32'(error), 32'd1);
        checkOutput("zeroHdr.hold", 32'(core_hold), 32'd1);
        checkOutput("zeroHdr.ready", 32'(byte_ready), 32'd0);

        // Recovery with a one-word image and an ignored start in DATA
        pulseStart();
        checkOutput("errRestart.error", 32'(error), 32'd0);
        expQ.push_back({32'h0, 32'h44332211});
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        pulseStart();
        checkOutput("startInData.busy", 32'(busy), 32'd1);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        @(negedge clk);
        checkOutput("oneWord.done", 32'(done), 32'd1);
        checkOutput("oneWord.hold", 32'(core_hold), 32'd0);

        // Oversize header
        pulseStart();
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("n65.error", 32'(error), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("n65.we", 32'(imem_we), 32'd0);

        // Maximum-size image
        pulseStart();
        applyStimulus(8'h40, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("n64.error", 32'(error), 32'd0);
        for (int w = 0; w < 64; w++) begin
            logic [7:0] b0, b1, b2, b3;
            b0 = 8'(4 * w);
            b1 = 8'(4 * w + 1);
            b2 = 8'(4 * w + 2);
            b3 = 8'(4 * w + 3);
            expQ.push_back({32'(4 * w), b3, b2, b1, b0});
            applyStimulus(b0, 1'b0);
            applyStimulus(b1, 1'b0);
            applyStimulus(b2, 1'b0);
            applyStimulus(b3, 1'b0);
        end
        @(negedge clk);
        checkOutput("n64.done", 32'(done), 32'd1);

        // Reset in the middle of a two-word load
        pulseStart();
        expQ.push_back({32'h0, 32'h04030201});
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h00, 1'b0);
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b0);
        areset = 1'b1;
        @(negedge clk);
        checkReset("midReset");
        @(negedge clk);
        areset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("afterReset.busy", 32'(busy), 32'd0);
        checkOutput("afterReset.hold", 32'(core_hold), 32'd1);
        checkOutput("pendingWrites", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
